cpu_trace_streamer: RTL and testbench

- Hardware-side source of the per-cycle CPU state dump. Counts cycles, stalls and flushes inside the pipelined CPU.
- On request, streams a snapshot over a valid/ready word interface to an external receiver (logger, UART bridge, FPGA debug core). The snapshot holds the header (cycle, stall, flush, PC), the register file and the first data-memory words.
- Sits beside the CPU top and uses spare read ports on the register file and data memory.

---
 rtl/cpu_trace_streamer.sv | 182 ++++++++++++++++++
 tb/tb_cpu_trace_streamer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_streamer.sv
// cpu_trace_streamer
// Counts CPU cycles, load-use stalls and IF/ID flushes. On request, it streams a snapshot
// (header, register file, first data-memory words) over a valid/ready word interface.
//
// Ports:
//   clk_i          clock, rising edge
//   start_i        asynchronous active-low reset; the block runs while high
//   stall_i        one-cycle stall event
//   flush_i        one-cycle flush event
//   pc_i           current PC
//   snap_req_i     snapshot request, level-sampled while idle
//   busy_o         snapshot in progress
//   reg_addr_o     register-file read address
//   reg_data_i     register-file read data (combinational from reg_addr_o)
//   dmem_addr_o    data-memory byte read address, word-aligned
//   dmem_data_i    data-memory read data (combinational from dmem_addr_o)
//   trace_data_o   stream word
//   trace_valid_o  stream word valid
//   trace_ready_i  receiver ready
//   trace_last_o   final word of the snapshot
//
// Optional build macro TRACE_CHECKSUM_EN: appends an XOR-of-all-words trailer word.

`timescale 1ns/1ps

module cpu_trace_streamer #(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned NUM_MEM_WORDS = 8,
  parameter int unsigned DMEM_AW       = 5,
  parameter int unsigned CNT_W         = 32
) (
  input  logic               clk_i,
  input  logic               start_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [31:0]        pc_i,
  input  logic               snap_req_i,
  output logic               busy_o,
  output logic [4:0]         reg_addr_o,
  input  logic [31:0]        reg_data_i,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  input  logic [31:0]        dmem_data_i,
  output logic [31:0]        trace_data_o,
  output logic               trace_valid_o,
  input  logic               trace_ready_i,
  output logic               trace_last_o
);

  typedef enum logic [2:0] {StIdle, StHdr, StRegs, StMem, StCsum, StLast} state_e;

  logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;
  logic [CNT_W-1:0] hdr_stall_q, hdr_flush_q;
  logic [31:0]      hdr_pc_q;
  logic [31:0]      csum_q;
  logic [31:0]      data_q;
  logic             valid_q, last_q, busy_q;
  logic [15:0]      sub_q;    // index of the next word to load within the current section
  state_e           state_q;
  logic [31:0]      word;
  logic             load;

  // Saturating event counters; they keep running during a snapshot.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (cycle_cnt_q != '1)            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (stall_i && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_i && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Read ports follow the pending index so the word is ready on the load edge.
  assign reg_addr_o  = (state_q == StRegs) ? 5'(sub_q) : 5'd0;
  assign dmem_addr_o = (state_q == StMem) ? DMEM_AW'({sub_q, 2'b00}) : '0;

  assign load = !valid_q || trace_ready_i;

  // Next word to load. In idle this is header word 0, loaded on the acceptance edge.
  always_comb begin
    word = '0;
    unique case (state_q)
      StIdle: word = 32'(cycle_cnt_q);
      StHdr: begin
        unique case (sub_q[1:0])
          2'd1:    word = 32'(hdr_stall_q);
          2'd2:    word = 32'(hdr_flush_q);
          default: word = hdr_pc_q;
        endcase
      end
      StRegs:  word = reg_data_i;
      StMem:   word = dmem_data_i;
      StCsum:  word = csum_q;
      default: word = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q     <= StIdle;
      sub_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
      csum_q      <= '0;
      hdr_stall_q <= '0;
      hdr_flush_q <= '0;
      hdr_pc_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (snap_req_i) begin
            hdr_stall_q <= stall_cnt_q;
            hdr_flush_q <= flush_cnt_q;
            hdr_pc_q    <= pc_i;
            data_q      <= word;
            csum_q      <= word;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            sub_q       <= 16'd1;
            state_q     <= StHdr;
          end
        end
        StHdr, StRegs, StMem, StCsum: begin
          if (load) begin
            data_q  <= word;
            csum_q  <= csum_q ^ word;
            valid_q <= 1'b1;
            sub_q   <= sub_q + 16'd1;
            unique case (state_q)
              StHdr: begin
                if (sub_q == 16'd3) begin
                  sub_q   <= '0;
                  state_q <= StRegs;
                end
              end
              StRegs: begin
                if (sub_q == 16'(NUM_REGS - 1)) begin
                  sub_q   <= '0;
                  state_q <= StMem;
                end
              end
              StMem: begin
                if (sub_q == 16'(NUM_MEM_WORDS - 1)) begin
                  sub_q <= '0;
`ifdef TRACE_CHECKSUM_EN
                  state_q <= StCsum;
`else
                  state_q <= StLast;
                  last_q  <= 1'b1;
`endif
                end
              end
              default: begin
                state_q <= StLast;
                last_q  <= 1'b1;
              end
            endcase
          end
        end
        StLast: begin
          if (valid_q && trace_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign trace_data_o  = data_q;
  assign trace_valid_o = valid_q;
  assign trace_last_o  = last_q;

endmodule

// File: tb/tb_cpu_trace_streamer.sv
// Self-checking bench for cpu_trace_streamer: reset state, event counters, full-rate and
// back-pressured snapshots, request-while-busy, reset abort, optional checksum trailer.

`timescale 1ns/1ps

module tb_cpu_trace_streamer;

  localparam int NR = 32;
  localparam int NM = 8;
`ifdef TRACE_CHECKSUM_EN
  localparam int NW = 4 + NR + NM + 1;
`else
  localparam int NW = 4 + NR + NM;
`endif

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] pc = 32'h20;
  logic        snap_req = 1'b0;
  logic        busy;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [4:0]  dmem_addr;
  logic [31:0] dmem_data;
  logic [31:0] tdata;
  logic        tvalid, tlast;
  logic        tready = 1'b1;

  logic [31:0] rf [NR];
  logic [31:0] dm [NM];

  assign reg_data  = rf[reg_addr];
  assign dmem_data = dm[dmem_addr[4:2]];

  cpu_trace_streamer #(
    .NUM_REGS(NR), .NUM_MEM_WORDS(NM), .DMEM_AW(5), .CNT_W(32)
  ) dut (
    .clk_i(clk), .start_i(start), .stall_i(stall), .flush_i(flush), .pc_i(pc),
    .snap_req_i(snap_req), .busy_o(busy), .reg_addr_o(reg_addr), .reg_data_i(reg_data),
    .dmem_addr_o(dmem_addr), .dmem_data_i(dmem_data), .trace_data_o(tdata),
    .trace_valid_o(tvalid), .trace_ready_i(tready), .trace_last_o(tlast)
  );

  always #5 clk = ~clk;

  // Reference event counts since the last reset release.
  int edge_m, stall_m, flush_m;
  always @(posedge clk or negedge start) begin
    if (!start) begin
      edge_m = 0; stall_m = 0; flush_m = 0;
    end else begin
      edge_m = edge_m + 1;
      if (stall) stall_m = stall_m + 1;
      if (flush) flush_m = flush_m + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] got_d[$];
  logic        got_l[$];
  logic [31:0] exp_w [NW];
  int          hc, hs, hf;

  task automatic build_exp();
    logic [31:0] x;
    exp_w[0] = hc; exp_w[1] = hs; exp_w[2] = hf; exp_w[3] = pc;
    for (int i = 0; i < NR; i++) exp_w[4+i] = rf[i];
    for (int k = 0; k < NM; k++) exp_w[4+NR+k] = dm[k];
`ifdef TRACE_CHECKSUM_EN
    x = '0;
    for (int i = 0; i < NW - 1; i++) x = x ^ exp_w[i];
    exp_w[NW-1] = x;
`else
    x = '0;
`endif
  endtask

  task automatic compare_stream(input string tag);
    build_exp();
    chk({tag, " word count"}, got_d.size(), NW);
    for (int i = 0; i < NW && i < got_d.size(); i++) begin
      chk($sformatf("%s word%0d data", tag, i), got_d[i], exp_w[i]);
      chk($sformatf("%s word%0d last", tag, i), {31'd0, got_l[i]}, {31'd0, i == NW - 1});
    end
  endtask

  // Called at a negedge while idle. mode 0: ready always high; mode 1: ready 1,0,0,1 pattern.
  task automatic collect(input int mode, input int ignore_at, output int cycles);
    int  cyc;
    bit  done, hold, rdy;
    logic [31:0] held_d;
    logic        held_l;
    got_d.delete(); got_l.delete();
    hc = edge_m; hs = stall_m; hf = flush_m;
    snap_req = 1'b1;
    tready   = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    chk("busy after accept", {31'd0, busy}, 32'd1);
    chk("valid after accept", {31'd0, tvalid}, 32'd1);
    cyc = 0; done = 0; hold = 0;
    while (!done && cyc < 400) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      if (hold) begin
        chk("hold valid", {31'd0, tvalid}, 32'd1);
        chk("hold data", tdata, held_d);
        chk("hold last", {31'd0, tlast}, {31'd0, held_l});
      end
      tready = rdy;
      if (tvalid && rdy) begin
        got_d.push_back(tdata);
        got_l.push_back(tlast);
        if (tlast) done = 1;
      end
      hold = tvalid && !rdy; held_d = tdata; held_l = tlast;
      snap_req = (cyc == ignore_at);
      if (mode == 1 && cyc == 2) rf[30] = 32'hDEAD_BEEF;  // live read: not yet streamed
      @(negedge clk);
      cyc++;
    end
    snap_req = 1'b0;
    tready   = 1'b1;
    if (!done) chk("stream timeout", 32'd0, 32'd1);
    chk("valid after last", {31'd0, tvalid}, 32'd0);
    chk("busy after last", {31'd0, busy}, 32'd0);
    cycles = cyc;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        last;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int cycles, acc, budget;
    tbl[0] = '{0,  32'd7,     1'b0};
    tbl[1] = '{1,  32'd3,     1'b0};
    tbl[2] = '{2,  32'd2,     1'b0};
    tbl[3] = '{3,  32'h20,    1'b0};
    tbl[4] = '{12, 32'd5,     1'b0};
    tbl[5] = '{36, 32'd5,     1'b0};
    tbl[6] = '{35, 32'h1000_0000 + 31 * 32'h111, 1'b0};
    tbl[7] = '{43, 32'hA500_0007, !(NW > 44)};

    for (int i = 0; i < NR; i++) rf[i] = 32'h1000_0000 + i * 32'h111;
    rf[8] = 32'd5;
    for (int k = 0; k < NM; k++) dm[k] = 32'hA500_0000 + k;
    dm[0] = 32'd5;

    // Reset state
    @(negedge clk);
    chk("rst valid", {31'd0, tvalid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst last", {31'd0, tlast}, 32'd0);
    chk("rst data", tdata, 32'd0);
    chk("rst reg_addr", {27'd0, reg_addr}, 32'd0);
    chk("rst dmem_addr", {27'd0, dmem_addr}, 32'd0);
    @(negedge clk);
    start = 1'b1;

    // 7 idle edges: stall on edges 2..4, flush on edges 4..5
    for (int e = 1; e <= 7; e++) begin
      stall = (e >= 2 && e <= 4);
      flush = (e == 4 || e == 5);
      @(negedge clk);
    end
    stall = 1'b0; flush = 1'b0;
    chk("idle valid", {31'd0, tvalid}, 32'd0);
    chk("idle busy", {31'd0, busy}, 32'd0);

    // Basic snapshot at cycle 7, with a request pulse while busy
    collect(0, 10, cycles);
    chk("full-rate cycles", cycles, NW);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].idx < got_d.size()) begin
        chk($sformatf("tbl word%0d data", tbl[i].idx), got_d[tbl[i].idx], tbl[i].data);
        chk($sformatf("tbl word%0d last", tbl[i].idx), {31'd0, got_l[tbl[i].idx]},
            {31'd0, tbl[i].last});
      end else begin
        chk($sformatf("tbl word%0d present", tbl[i].idx), 32'd0, 32'd1);
      end
    end
    compare_stream("basic");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no restart valid", {31'd0, tvalid}, 32'd0);
    end

    // Backpressure with a mid-stream register write
    pc = 32'h0000_1234;
    collect(1, -1, cycles);
    compare_stream("bp");
    if (got_d.size() > 34) chk("bp live r30", got_d[34], 32'hDEAD_BEEF);

    // Abort by reset after 20 accepted words
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    acc = 0; budget = 0;
    while (acc < 20 && budget < 100) begin
      if (tvalid && tready) acc++;
      if (acc < 20) @(negedge clk);
      budget++;
    end
    chk("abort reached word 20", acc, 20);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("abort valid", {31'd0, tvalid}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort last", {31'd0, tlast}, 32'd0);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post-abort idle", {31'd0, tvalid}, 32'd0);
    end
    collect(0, -1, cycles);
    if (got_d.size() > 2) begin
      chk("post-abort cycle", got_d[0], 32'd10);
      chk("post-abort stall", got_d[1], 32'd0);
      chk("post-abort flush", got_d[2], 32'd0);
    end
    compare_stream("post-abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end

endmodule
